// File: rtl/featuremap_pkg.sv
// Shared sizing helpers and the round/saturate/ReLU stage for featuremap_conv2d_mc.
package featuremap_pkg;

  localparam int unsigned ROUND_W = 64;

  function automatic int unsigned num_slots(input int unsigned ch);
    return 9 * ch;
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ch);
    return 2 * dw + $clog2(9 * ch) + 1;
  endfunction

  function automatic int unsigned slot_idx(input int unsigned ch, input int unsigned ky,
                                           input int unsigned kx);
    return ch * 9 + ky * 3 + kx;
  endfunction

  // Round half-up, drop frac bits, clamp to the dw-bit signed range, optional ReLU.
  function automatic logic signed [ROUND_W-1:0] round_sat(input logic signed [ROUND_W-1:0] acc,
                                                          input int unsigned dw,
                                                          input int unsigned frac,
                                                          input logic relu);
    logic signed [ROUND_W-1:0] r;
    logic signed [ROUND_W-1:0] hi;
    logic signed [ROUND_W-1:0] lo;
    r = acc;
    if (frac != 0) r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/featuremap_conv2d_mc_line_buffer.sv
// Per-channel two-row delay plus 3x3 window; the newest column is taken combinationally
// so products can be registered on the same edge that accepts the pixel.
module fm_line_buffer #(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned IMG_WIDTH  = 34,
  localparam int unsigned COL_W      = $clog2(IMG_WIDTH)
) (
  input  logic                         clk,
  input  logic                         en_i,
  input  logic [COL_W-1:0]             col_i,
  input  logic [DATA_WIDTH-1:0]        pix_i,
  output logic signed [DATA_WIDTH-1:0] w00_o,
  output logic signed [DATA_WIDTH-1:0] w01_o,
  output logic signed [DATA_WIDTH-1:0] w02_o,
  output logic signed [DATA_WIDTH-1:0] w10_o,
  output logic signed [DATA_WIDTH-1:0] w11_o,
  output logic signed [DATA_WIDTH-1:0] w12_o,
  output logic signed [DATA_WIDTH-1:0] w20_o,
  output logic signed [DATA_WIDTH-1:0] w21_o,
  output logic signed [DATA_WIDTH-1:0] w22_o
);

  logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] c0_q  [3];
  logic [DATA_WIDTH-1:0] c1_q  [3];

  // Contents are never reset: window-valid gating in the parent hides stale data.
  always_ff @(posedge clk) begin
    if (en_i) begin
      lb1_q[col_i] <= lb0_q[col_i];
      lb0_q[col_i] <= pix_i;
      c1_q[0]      <= lb1_q[col_i];
      c1_q[1]      <= lb0_q[col_i];
      c1_q[2]      <= pix_i;
      c0_q         <= c1_q;
    end
  end

  assign w00_o = c0_q[0];
  assign w10_o = c0_q[1];
  assign w20_o = c0_q[2];
  assign w01_o = c1_q[0];
  assign w11_o = c1_q[1];
  assign w21_o = c1_q[2];
  assign w02_o = lb1_q[col_i];
  assign w12_o = lb0_q[col_i];
  assign w22_o = pix_i;

endmodule

// File: rtl/featuremap_conv2d_mc.sv
// Multi-channel 3x3 convolution: raster counters, runtime weight/bias registers,
// product stage and sum/bias/round/saturate stage.
module featuremap_conv2d_mc
  import featuremap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned IMG_WIDTH  = 34,
  parameter int unsigned IMG_HEIGHT = 34,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_load_i,
  input  logic [$clog2(9*CHANNELS)-1:0]  w_addr_i,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic                           bias_load_i,
  input  logic [DATA_WIDTH-1:0]          bias_data_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [DATA_WIDTH*CHANNELS-1:0] in_data_i,
  output logic                           out_valid_o,
  output logic [DATA_WIDTH-1:0]          out_data_o,
  output logic                           frame_done_o
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned NSLOT = num_slots(CHANNELS);
  localparam int unsigned ACC_W = acc_width(DW, CHANNELS);
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    accept_c, col_last_c, row_last_c, win_valid_c, frame_last_c;
  logic                    v1_q, last1_q;
  logic signed [DW-1:0]    w_q [NSLOT];
  logic signed [DW-1:0]    bias_q;
  logic signed [DW-1:0]    win_c [CHANNELS][9];
  logic signed [PW-1:0]    prod_d [NSLOT];
  logic signed [PW-1:0]    prod_q [NSLOT];
  logic signed [ACC_W-1:0] acc_c;

  // Load cycles own the register file port, so input is stalled while they happen.
  assign in_ready_o   = ~w_load_i & ~bias_load_i;
  assign accept_c     = in_valid_i & in_ready_o;
  assign col_last_c   = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last_c   = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign win_valid_c  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign frame_last_c = row_last_c & col_last_c;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_c) begin
      if (col_last_c) begin
        col_d = '0;
        row_d = row_last_c ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NSLOT); i++) w_q[i] <= '0;
      bias_q <= '0;
    end else begin
      if (w_load_i && (32'(w_addr_i) < NSLOT)) w_q[w_addr_i] <= w_data_i;
      if (bias_load_i) bias_q <= bias_data_i;
    end
  end

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
    fm_line_buffer #(
      .DATA_WIDTH(DW),
      .IMG_WIDTH (IMG_WIDTH)
    ) u_lb (
      .clk  (clk),
      .en_i (accept_c),
      .col_i(col_q),
      .pix_i(in_data_i[c*DW +: DW]),
      .w00_o(win_c[c][0]),
      .w01_o(win_c[c][1]),
      .w02_o(win_c[c][2]),
      .w10_o(win_c[c][3]),
      .w11_o(win_c[c][4]),
      .w12_o(win_c[c][5]),
      .w20_o(win_c[c][6]),
      .w21_o(win_c[c][7]),
      .w22_o(win_c[c][8])
    );
  end

  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          prod_d[slot_idx(c, ky, kx)] = PW'(win_c[c][ky*3+kx]) * PW'(w_q[slot_idx(c, ky, kx)]);
  end

  // Product registers only need to move when a valid window enters the pipe.
  always_ff @(posedge clk) begin
    if (accept_c && win_valid_c) prod_q <= prod_d;
  end

  always_comb begin
    acc_c = ACC_W'(bias_q) <<< FRAC_BITS;
    for (int i = 0; i < int'(NSLOT); i++) acc_c = acc_c + ACC_W'(prod_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      v1_q         <= 1'b0;
      last1_q      <= 1'b0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      v1_q         <= accept_c & win_valid_c;
      last1_q      <= accept_c & win_valid_c & frame_last_c;
      out_valid_o  <= v1_q;
      frame_done_o <= v1_q & last1_q;
      if (v1_q) out_data_o <= DW'(round_sat(ROUND_W'(acc_c), DW, FRAC_BITS, RELU_EN));
    end
  end

endmodule

// File: tb/tb_featuremap_conv2d_mc.sv
// Directed bench for featuremap_conv2d_mc: a ReLU and a linear instance share stimulus
// on a 4x8, 3-channel frame; results are scored against table values or a direct model.
module tb_featuremap_conv2d_mc;

  localparam int W = 4, H = 8, CH = 3, NS = 27;

  logic              clk = 1'b0, rst = 1'b1;
  logic              w_load = 1'b0, bias_load = 1'b0, in_valid = 1'b0;
  logic [4:0]        w_addr = '0;
  logic [15:0]       w_data = '0, bias_data = '0;
  logic [47:0]       in_data = '0;
  logic [1:0]        rdy, ov, fd;
  logic [1:0][15:0]  od;

  always #5 clk = ~clk;

  featuremap_conv2d_mc #(.DATA_WIDTH(16), .FRAC_BITS(8), .CHANNELS(CH), .IMG_WIDTH(W),
                         .IMG_HEIGHT(H), .RELU_EN(1'b1)) u_dut_relu (
    .clk(clk), .rst(rst), .w_load_i(w_load), .w_addr_i(w_addr), .w_data_i(w_data),
    .bias_load_i(bias_load), .bias_data_i(bias_data), .in_valid_i(in_valid),
    .in_ready_o(rdy[0]), .in_data_i(in_data), .out_valid_o(ov[0]), .out_data_o(od[0]),
    .frame_done_o(fd[0]));

  featuremap_conv2d_mc #(.DATA_WIDTH(16), .FRAC_BITS(8), .CHANNELS(CH), .IMG_WIDTH(W),
                         .IMG_HEIGHT(H), .RELU_EN(1'b0)) u_dut_lin (
    .clk(clk), .rst(rst), .w_load_i(w_load), .w_addr_i(w_addr), .w_data_i(w_data),
    .bias_load_i(bias_load), .bias_data_i(bias_data), .in_valid_i(in_valid),
    .in_ready_o(rdy[1]), .in_data_i(in_data), .out_valid_o(ov[1]), .out_data_o(od[1]),
    .frame_done_o(fd[1]));

  typedef struct { int cyc; logic [15:0] val; logic last; } exp_t;
  typedef struct {
    string name; logic [15:0] w0, w1, w2; bit single;
    logic [15:0] p0, p1, p2, bias, ea, eb;
  } vec_t;

  exp_t               exp_q [2][$];
  vec_t               vt [10];
  logic signed [15:0] wt [NS];
  logic signed [15:0] bias;
  logic signed [15:0] frame [H][W][CH];
  int                 cyc = 0, total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Scoreboard: every out_valid must match the oldest pending window in cycle, data and frame_done.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (ov[d]) begin
        if (exp_q[d].size() == 0) chk(d ? "lin_spurious" : "relu_spurious", 32'd1, 32'd0);
        else begin
          e = exp_q[d].pop_front();
          chk(d ? "lin_latency" : "relu_latency", 32'(cyc), 32'(e.cyc));
          chk(d ? "lin_data" : "relu_data", 32'(od[d]), 32'(e.val));
          chk(d ? "lin_fdone" : "relu_fdone", 32'(fd[d]), 32'(e.last));
        end
      end else if (fd[d]) chk(d ? "lin_fdone_idle" : "relu_fdone_idle", 32'd1, 32'd0);
    end
  end

  function automatic vec_t mk(input string n, input logic [15:0] w0, w1, w2, input bit s,
                              input logic [15:0] p0, p1, p2, b, ea, eb);
    vec_t v;
    v.name = n; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.single = s;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.bias = b; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  function automatic logic [15:0] model(input int r, input int c, input bit relu);
    longint acc;
    acc = longint'(bias) * 256;
    for (int ch = 0; ch < CH; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++)
          acc += longint'(frame[r-2+ky][c-2+kx][ch]) * longint'(wt[ch*9+ky*3+kx]);
    acc = (acc + 128) >>> 8;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  task automatic load_all();
    for (int i = 0; i < NS + 1; i++) begin
      w_load    = 1'b1;
      w_addr    = 5'(i);
      w_data    = 16'h7FFF;
      if (i < NS) w_data = wt[i];
      bias_load = (i == 0);
      bias_data = bias;
      @(posedge clk); #1;
    end
    w_load = 1'b0; bias_load = 1'b0;
  endtask

  task automatic feed(input bit use_model, input logic [15:0] ea, input logic [15:0] eb,
                      input int stall_at, input int stop_at);
    int idx = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        in_valid = 1'b1;
        in_data  = {frame[r][c][2], frame[r][c][1], frame[r][c][0]};
        if (idx == stall_at) begin
          for (int k = 0; k < 3; k++) begin
            w_load = 1'b1; w_addr = 5'(k); w_data = 16'h0200;
            bias_load = (k == 1); bias_data = 16'h0040;
            #1 chk("stall_ready_low", 32'(rdy), 32'd0);
            @(posedge clk); #1;
            wt[k] = 16'h0200;
            if (k == 1) bias = 16'h0040;
          end
          w_load = 1'b0; bias_load = 1'b0;
          #1 chk("stall_ready_high", 32'(rdy), 32'd3);
        end
        if (r >= 2 && c >= 2) begin
          exp_q[0].push_back('{cyc + 2, use_model ? model(r, c, 1'b1) : ea, (r == H-1 && c == W-1)});
          exp_q[1].push_back('{cyc + 2, use_model ? model(r, c, 1'b0) : eb, (r == H-1 && c == W-1)});
        end
        @(posedge clk); #1;
        if (idx == stop_at) begin
          in_valid = 1'b0;
          return;
        end
        idx++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_left_relu"}, 32'(exp_q[0].size()), 32'd0);
    chk({nm, "_left_lin"}, 32'(exp_q[1].size()), 32'd0);
    exp_q[0].delete(); exp_q[1].delete();
  endtask

  task automatic ramp_setup();
    for (int i = 0; i < NS; i++) wt[i] = 16'(((i * 37) % 19) * 16 - 120);
    bias = 16'hFF80;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int ch = 0; ch < CH; ch++) frame[r][c][ch] = 16'((r * 7 + c * 3 + ch * 5) * 32 - 300);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk("basic",     16'h0100, 16'h0000, 16'h0000, 0, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0900, 16'h0900);
    vt[1] = mk("xchan",     16'h0100, 16'h0200, 16'h0300, 0, 16'h0080, 16'h0080, 16'h0080, 16'h0100, 16'h1C00, 16'h1C00);
    vt[2] = mk("sat_pos",   16'h0100, 16'h0000, 16'h0000, 0, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF);
    vt[3] = mk("neg",       16'hFF00, 16'h0000, 16'h0000, 0, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF700);
    vt[4] = mk("sat_neg",   16'hFF00, 16'h0000, 16'h0000, 0, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000);
    vt[5] = mk("round_up",  16'h0001, 16'h0000, 16'h0000, 1, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001);
    vt[6] = mk("round_dn",  16'h0001, 16'h0000, 16'h0000, 1, 16'h007F, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    vt[7] = mk("round_neg", 16'hFFFF, 16'h0000, 16'h0000, 1, 16'h0081, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    vt[8] = mk("mixed",     16'h0080, 16'hFF80, 16'h0040, 0, 16'h0200, 16'h0100, 16'h0400, 16'hFF00, 16'h0C80, 16'h0C80);
    vt[9] = mk("neg_bias",  16'h0100, 16'h0000, 16'h0000, 0, 16'hFF80, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'hFC00);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy), 32'd3);
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_frame_done", 32'(fd), 32'd0);
    chk("rst_out_data", 32'(od), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < NS; i++) begin
        wt[i] = (i < 9) ? vt[v].w0 : (i < 18) ? vt[v].w1 : vt[v].w2;
        if (vt[v].single && i != 0) wt[i] = '0;
      end
      bias = vt[v].bias;
      load_all();
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          frame[r][c][0] = vt[v].p0; frame[r][c][1] = vt[v].p1; frame[r][c][2] = vt[v].p2;
        end
      feed(1'b0, vt[v].ea, vt[v].eb, -1, -1);
      drain(vt[v].name);
    end

    // Varying frame with a three-cycle weight/bias load in the middle of row 3.
    ramp_setup();
    load_all();
    feed(1'b1, '0, '0, 14, -1);
    drain("ramp_stall");

    // Reset right after accepting (5,3): (5,2) is at the output and (5,3) is in stage 1.
    ramp_setup();
    load_all();
    feed(1'b1, '0, '0, -1, 23);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov), 32'd0);
    chk("midrst_out_data", 32'(od), 32'd0);
    chk("midrst_frame_done", 32'(fd), 32'd0);
    exp_q[0].delete(); exp_q[1].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_ready", 32'(rdy), 32'd3);
    feed(1'b0, '0, '0, -1, -1);
    drain("after_rst_zero_weights");
    load_all();
    feed(1'b1, '0, '0, -1, -1);
    drain("after_rst_frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
